wddl_xorn_pipe: RTL
===================

WDDL_XORN_PIPE -- requirements
Module: wddl_xorn_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: bit width of each dual-rail operand (legal 1..32).
REQ-002 The block SHALL have parameter NUM_IN, default 4: number of dual-rail operands XORed together (legal 2..8).
REQ-003 The block SHALL have localparam LEVELS = ceil(log2(NUM_IN)): number of tree levels and the pipeline depth.
REQ-004 clk_in  input  1  single clock; all state updates on rising edge.
REQ-005 rst_in  input  1  asynchronous, active-high reset.
REQ-006 valid_in  input  1  1 = evaluate wave on the input rails; 0 = precharge wave.
REQ-007 d_p_in  input  NUM_IN*WIDTH  true rails; operand k occupies bits [k*WIDTH +: WIDTH].
REQ-008 d_n_in  input  NUM_IN*WIDTH  complement rails, same packing as d_p_in.
REQ-009 d_p_out  output  WIDTH  true rail of the XOR of all operands.
REQ-010 d_n_out  output  WIDTH  complement rail of the XOR of all operands.
REQ-011 valid_out  output  1  1 = d_p_out/d_n_out carry an evaluate wave.
REQ-012 err_out  output  1  sticky dual-rail protocol fault flag.
REQ-013 err_cnt_out  output  8  saturating count of faulty input cycles.

Function
REQ-014 Each tree level SHALL XOR operand pairs in WDDL form: p = (a_p&b_n)|(a_n&b_p), n = (a_p&b_p)|(a_n&b_n); no inverters on any rail path.
REQ-015 At each level, pairs SHALL be formed in index order (0,1),(2,3),...; an odd leftover operand SHALL pass through unchanged into that level's register.
REQ-016 Every level output, both rails, SHALL be registered; latency from input to output SHALL be exactly LEVELS cycles (NUM_IN=4 gives 2; NUM_IN=5 gives 3).
REQ-017 valid_in SHALL be delayed through a LEVELS-deep shift register aligned with the data and appear as valid_out.
REQ-018 When valid_in=0, the precharge wave (all rails 0) SHALL propagate through the pipeline, so d_p_out=d_n_out=0 whenever valid_out=0 in fault-free operation.
REQ-019 Back-to-back evaluate cycles without an intervening precharge SHALL be accepted, with one result per cycle; full throughput.
REQ-020 Input fault in a cycle SHALL be defined as any of: valid_in=1 with any bit where p=n (both 0 or both 1); or valid_in=0 with any rail 1.
REQ-021 On an input fault, err_out SHALL set to 1 on the next rising edge and hold until reset.
REQ-022 On each faulty cycle, err_cnt_out SHALL increment by 1 on the next rising edge, saturating at 255 with no wrap.
REQ-023 A faulty cycle SHALL still propagate its data unchanged; the block does not mask, repair or drop data.
REQ-024 Fault detection SHALL be computed on the registered-input boundary; it SHALL NOT add latency to the data path.

Reset
REQ-025 While rst_in=1, all pipeline rails, valid_out, err_out and err_cnt_out SHALL be 0, asynchronously and immediately.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight waves; after release, the first valid_out=1 SHALL appear exactly LEVELS cycles after the first valid_in=1 sampled.
REQ-027 Deassertion of rst_in SHALL take effect at the next rising edge; no output changes between the deassertion and that edge.

Verification
REQ-028 NUM_IN=4, WIDTH=8: valid_in=1, operands 0x0F/0xF0, 0xFF/0x00, 0x33/0xCC, 0x55/0xAA (p/n) -> 2 cycles later d_p_out=0x96, d_n_out=0x69, valid_out=1, err_out=0.
REQ-029 Alternate evaluate and precharge for 10 cycles with random legal operands -> outputs match the reference XOR on evaluate cycles and all rails are 0 on precharge cycles.
REQ-030 Drive one evaluate cycle with bit 3 of operand 2 as p=n=1 -> err_out=1 and err_cnt_out=1 one cycle later; data still propagates; err_out stays 1 for 20 further clean cycles.
REQ-031 Drive 300 consecutive faulty cycles (valid_in=0, d_p_in bit 0=1) -> err_cnt_out reaches 255 and stays at 255.
REQ-032 NUM_IN=5, WIDTH=4, operands 0x1,0x2,0x4,0x8,0xF in consecutive evaluate cycles -> latency 3, d_p_out=0x0, d_n_out=0xF.
REQ-033 Assert rst_in mid-stream with a wave in flight -> outputs 0 immediately; after release, no stale valid_out appears and the first new result arrives exactly LEVELS cycles after its valid_in.

Source files
------------

// File: rtl/wddl_xorn_pipe.sv
// wddl_xorn_pipe
// Pipelined N-input XOR in Wave Dynamic Differential Logic form. Each
// operand is carried on a true rail (d_p) and a complement rail (d_n).
// Evaluate waves carry complementary rails. Precharge waves carry all
// rails at 0.
//
// The operands are reduced by a binary tree. Each level pairs operands in
// index order. An odd leftover operand passes through that level's register
// unchanged. Every level is registered, so the result appears LEVELS cycles
// after the operands are sampled.
//
// The rail paths use only AND and OR gates. This keeps the logic monotonic,
// so a precharge wave (all rails 0) stays all-zero as it moves through the tree.
//
// A protocol checker watches the input boundary and updates a sticky error
// flag and a saturating fault counter. It sits beside the data path, so it
// adds no latency and never changes the data.
module wddl_xorn_pipe #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    valid_in,
    input  logic [NUM_IN*WIDTH-1:0] d_p_in,
    input  logic [NUM_IN*WIDTH-1:0] d_n_in,
    output logic [WIDTH-1:0]        d_p_out,
    output logic [WIDTH-1:0]        d_n_out,
    output logic                    valid_out,
    output logic                    err_out,
    output logic [7:0]              err_cnt_out
);

    localparam int LEVELS = $clog2(NUM_IN);

    // Number of operands present at the input of tree level lvl.
    // Level 0 is the raw input boundary.
    function automatic int ops_at(input int lvl);
        int c;
        c = NUM_IN;
        for (int i = 0; i < lvl; i++) begin
            c = (c + 1) / 2;
        end
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Reduction tree
    // ------------------------------------------------------------------
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int CNT = ops_at(l);

        logic [CNT*WIDTH-1:0] rail_p;
        logic [CNT*WIDTH-1:0] rail_n;

        if (l == 0) begin : g_in
            assign rail_p = d_p_in;
            assign rail_n = d_n_in;
        end else begin : g_stage
            localparam int PREV  = ops_at(l - 1);
            localparam int NPAIR = PREV / 2;

            logic [PREV*WIDTH-1:0]  src_p;
            logic [PREV*WIDTH-1:0]  src_n;
            logic [NPAIR*WIDTH-1:0] pair_p;
            logic [NPAIR*WIDTH-1:0] pair_n;
            logic [CNT*WIDTH-1:0]   p_d;
            logic [CNT*WIDTH-1:0]   n_d;
            logic [CNT*WIDTH-1:0]   p_q;
            logic [CNT*WIDTH-1:0]   n_q;

            assign src_p = g_lvl[l-1].rail_p;
            assign src_n = g_lvl[l-1].rail_n;

            // WDDL XOR of each adjacent operand pair. The rails are cross-coupled.
            // No rail is ever inverted.
            always_comb begin
                pair_p = '0;
                pair_n = '0;
                for (int k = 0; k < NPAIR; k++) begin
                    pair_p[k*WIDTH +: WIDTH] =
                        (src_p[(2*k)*WIDTH +: WIDTH] & src_n[(2*k+1)*WIDTH +: WIDTH]) |
                        (src_n[(2*k)*WIDTH +: WIDTH] & src_p[(2*k+1)*WIDTH +: WIDTH]);
                    pair_n[k*WIDTH +: WIDTH] =
                        (src_p[(2*k)*WIDTH +: WIDTH] & src_p[(2*k+1)*WIDTH +: WIDTH]) |
                        (src_n[(2*k)*WIDTH +: WIDTH] & src_n[(2*k+1)*WIDTH +: WIDTH]);
                end
            end

            // An odd operand count leaves the top operand unpaired.
            // That operand rides along in the highest slot.
            if ((PREV % 2) == 1) begin : g_odd
                assign p_d = {src_p[PREV*WIDTH-1 -: WIDTH], pair_p};
                assign n_d = {src_n[PREV*WIDTH-1 -: WIDTH], pair_n};
            end else begin : g_even
                assign p_d = pair_p;
                assign n_d = pair_n;
            end

            // Level register for both rails. Reset drives every rail to the precharge state.
            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    p_q <= '0;
                    n_q <= '0;
                end else begin
                    p_q <= p_d;
                    n_q <= n_d;
                end
            end

            assign rail_p = p_q;
            assign rail_n = n_q;
        end
    end

    assign d_p_out = g_lvl[LEVELS].rail_p;
    assign d_n_out = g_lvl[LEVELS].rail_n;

    // ------------------------------------------------------------------
    // Valid alignment
    // ------------------------------------------------------------------
    logic [LEVELS-1:0] vld_d;
    logic [LEVELS-1:0] vld_q;

    // Shift valid_in along the tree so that it stays aligned with its wave.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = valid_in;
        for (int i = 1; i < LEVELS; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    // Valid shift register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign valid_out = vld_q[LEVELS-1];

    // ------------------------------------------------------------------
    // Dual-rail protocol checker
    // ------------------------------------------------------------------
    logic       fault;
    logic       err_d;
    logic       err_q;
    logic [7:0] cnt_d;
    logic [7:0] cnt_q;

    // A cycle is faulty in either of two cases.
    // Evaluate: some bit has equal rails (00 spacer or 11 collision).
    // Precharge: some rail is high.
    always_comb begin
        fault = 1'b0;
        if (valid_in) begin
            fault = |(~(d_p_in ^ d_n_in));
        end else begin
            fault = |(d_p_in | d_n_in);
        end
    end

    // Sticky flag and saturating counter update.
    always_comb begin
        err_d = err_q | fault;
        cnt_d = cnt_q;
        if (fault && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Checker state register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            err_q <= 1'b0;
            cnt_q <= 8'd0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign err_out     = err_q;
    assign err_cnt_out = cnt_q;

endmodule
